crc_frame_serializer: RTL and testbench

Upstream feeder for the serial CRC-8 generator. Accepts bytes from the parallel datapath over a valid/ready handshake and buffers them in a small FIFO. Once a frame is complete, shifts it out serially with `ser_active` held high for exactly the frame's bits, then holds `ser_active` low for a guard gap so the CRC stage can emit its 8 CRC bits before the next frame.

---
 rtl/crc_frame_serializer.sv | 200 ++++++++++++++++++++
 tb/tb_crc_frame_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_serializer.sv
// rtl/crc_frame_serializer.sv - byte FIFO and frame serializer feeding the serial CRC-8 stage
//
// Purpose: buffers {last, byte} entries from the parallel datapath.
//   Once a whole frame is queued, or the FIFO is full, it shifts the frame out
//   one bit per cycle with ser_active framing the bits. It then idles GAP
//   cycles so the CRC stage can append its 8 CRC bits.
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   in_data, in_valid, in_last         byte input with handshake
//   in_ready                           FIFO not full (combinational)
//   ser_data, ser_active               serial bit and frame window to the CRC stage
//   busy                               serializer not in IDLE
//   underrun                           one-cycle pulse when a frame runs dry before its last byte
// Configuration macro:
//   SER_MSB_FIRST_EN                   serialize each byte MSB first (default is LSB first)
module crc_frame_serializer #(
    parameter int DEPTH = 8,
    parameter int GAP   = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       ser_data,
    output logic       ser_active,
    output logic       busy,
    output logic       underrun
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] frame_cnt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [8:0]    head;

    state_t        state;
    state_t        state_n;
    logic [7:0]    shreg;
    logic [7:0]    shreg_n;
    logic          held_last;
    logic          held_last_n;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_n;
    logic          ser_data_n;
    logic          ser_active_n;
    logic          underrun_n;

    // shreg holds the bits not yet driven; the next bit always sits at the
    // end selected by the shift direction.
`ifdef SER_MSB_FIRST_EN
    function automatic logic first_bit(input logic [7:0] b);
        return b[7];
    endfunction
    function automatic logic [7:0] advance(input logic [7:0] b);
        return {b[6:0], 1'b0};
    endfunction
`else
    function automatic logic first_bit(input logic [7:0] b);
        return b[0];
    endfunction
    function automatic logic [7:0] advance(input logic [7:0] b);
        return {1'b0, b[7:1]};
    endfunction
`endif

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, in_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            case ({push && in_last, pop && head[8]})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            held_last  <= 1'b0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ser_data   <= 1'b0;
            ser_active <= 1'b0;
            underrun   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            held_last  <= held_last_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            ser_data   <= ser_data_n;
            ser_active <= ser_active_n;
            underrun   <= underrun_n;
            busy       <= (state_n != ST_IDLE);
        end
    end

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        held_last_n  = held_last;
        bit_cnt_n    = bit_cnt;
        gap_cnt_n    = gap_cnt;
        ser_data_n   = ser_data;
        ser_active_n = ser_active;
        underrun_n   = 1'b0;
        pop          = 1'b0;
        case (state)
            ST_IDLE: begin
                ser_data_n   = 1'b0;
                ser_active_n = 1'b0;
                // A full FIFO with no complete frame starts anyway so that
                // frames longer than DEPTH can stream.
                if (frame_cnt != '0 || full) begin
                    pop          = 1'b1;
                    shreg_n      = advance(head[7:0]);
                    held_last_n  = head[8];
                    ser_data_n   = first_bit(head[7:0]);
                    ser_active_n = 1'b1;
                    bit_cnt_n    = '0;
                    state_n      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt != 3'd7) begin
                    bit_cnt_n  = bit_cnt + 3'd1;
                    ser_data_n = first_bit(shreg);
                    shreg_n    = advance(shreg);
                end else if (!held_last && !empty) begin
                    // Chain straight into the next byte with no idle bit.
                    pop          = 1'b1;
                    shreg_n      = advance(head[7:0]);
                    held_last_n  = head[8];
                    ser_data_n   = first_bit(head[7:0]);
                    bit_cnt_n    = '0;
                end else begin
                    // Either a clean end of frame or the producer fell behind;
                    // both close the window so the CRC stage ends the frame.
                    underrun_n   = !held_last;
                    ser_data_n   = 1'b0;
                    ser_active_n = 1'b0;
                    gap_cnt_n    = '0;
                    state_n      = ST_GAP;
                end
            end
            ST_GAP: begin
                ser_data_n   = 1'b0;
                ser_active_n = 1'b0;
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_crc_frame_serializer.sv
// tb/tb_crc_frame_serializer.sv - directed self-checking bench for crc_frame_serializer
`timescale 1ns/1ps
module tb_crc_frame_serializer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       ser_data;
    logic       ser_active;
    logic       busy;
    logic       underrun;

    int errors = 0;
    int checks = 0;

    crc_frame_serializer #(.DEPTH(8), .GAP(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .ser_data   (ser_data),
        .ser_active (ser_active),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic bitof(input logic [7:0] b, input int j);
`ifdef SER_MSB_FIRST_EN
        return b[7-j];
`else
        return b[j];
`endif
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] b);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("%s active b%0d", tag, j), ser_active, 1);
            check($sformatf("%s data b%0d", tag, j), ser_data, bitof(b, j));
            step();
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy || dut.frame_cnt != 0) && n < 300) begin
            step();
            n++;
        end
        check({tag, " idle"}, busy, 0);
    endtask

    initial begin
        logic [7:0] seq;
        int         n;
        int         pulses;

        // Reset state
        #1;
        check("rst ser_data", ser_data, 0);
        check("rst ser_active", ser_active, 0);
        check("rst busy", busy, 0);
        check("rst underrun", underrun, 0);
        check("rst in_ready", in_ready, 1);
        step();
        step();
        rst = 1'b1;

        // Single frame 0xA5: 1,0,1,0,0,1,0,1 (palindromic, same in either order)
        push_byte(8'hA5, 1'b1);
        check("a5 not yet active", ser_active, 0);
        step();
        expect_byte("a5", 8'hA5);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("a5 gap%0d active", k), ser_active, 0);
            check($sformatf("a5 gap%0d busy", k), busy, 1);
            step();
        end
        check("a5 busy falls", busy, 0);

        // Back-to-back frames {01,80} and {3C}
        push_byte(8'h01, 1'b0);
        push_byte(8'h80, 1'b1);
        push_byte(8'h3C, 1'b1);
        expect_byte("b2b 01", 8'h01);
        expect_byte("b2b 80", 8'h80);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("b2b gap%0d active", k), ser_active, 0);
            step();
        end
        check("b2b idle cycle active", ser_active, 0);
        step();
        expect_byte("b2b 3C", 8'h3C);
        check("b2b end active", ser_active, 0);
        wait_idle("b2b");

        // Bit order: frame 0x01
`ifdef SER_MSB_FIRST_EN
        seq = 8'b1000_0000;
`else
        seq = 8'b0000_0001;
`endif
        push_byte(8'h01, 1'b1);
        step();
        for (int j = 0; j < 8; j++) begin
            check($sformatf("order bit%0d", j), ser_data, seq[j]);
            step();
        end
        wait_idle("order");

        // Simultaneous push(last) and pop(last) with 2 frames queued
        push_byte(8'h5A, 1'b1);
        push_byte(8'h11, 1'b1);
        push_byte(8'h22, 1'b1);
        n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        check("pp idle reached", busy, 0);
        check("pp frame_cnt before", dut.frame_cnt, 2);
        check("pp count before", dut.count, 2);
        push_byte(8'h33, 1'b1);
        check("pp frame_cnt after", dut.frame_cnt, 2);
        check("pp count after", dut.count, 2);
        expect_byte("pp 11", 8'h11);
        wait_idle("pp drain");
        check("pp drained count", dut.count, 0);

        // Fill 8 non-last bytes during GAP, stream on full, then underrun
        push_byte(8'h42, 1'b1);
        step();
        n = 0;
        while (ser_active && n < 20) begin
            step();
            n++;
        end
        check("fill in gap busy", busy, 1);
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0);
        check("fill in_ready low", in_ready, 0);
        check("fill count 8", dut.count, 8);
        check("fill still gap", busy, 1);
        push_byte(8'hEE, 1'b0);
        check("fill 9th ignored", dut.count, 8);
        check("fill idle cycle", busy, 0);
        step();
        check("fill in_ready rises", in_ready, 1);
        for (int i = 0; i < 8; i++) expect_byte($sformatf("fill byte%0d", i), 8'h10 + 8'(i));
        check("underrun pulse", underrun, 1);
        check("underrun active low", ser_active, 0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (underrun) pulses++;
        end
        check("underrun single pulse", pulses, 0);
        wait_idle("underrun");

        // Reset in the 3rd bit of the 2nd byte
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b1);
        for (int k = 0; k < 11; k++) step();
        check("mid active", ser_active, 1);
        check("mid bit", ser_data, bitof(8'h22, 2));
        rst = 1'b0;
        #1;
        check("async rst active", ser_active, 0);
        check("async rst busy", busy, 0);
        step();
        check("rst edge active", ser_active, 0);
        check("rst edge busy", busy, 0);
        check("rst edge in_ready", in_ready, 1);
        check("rst edge count", dut.count, 0);
        rst = 1'b1;
        step();
        check("post rst idle", ser_active, 0);
        push_byte(8'hFF, 1'b1);
        step();
        expect_byte("post rst FF", 8'hFF);
        check("post rst end", ser_active, 0);
        wait_idle("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
